// File: rtl/femto_mem_responder_pkg.sv
// Shared definitions for the FemtoRV32 memory responder: FSM states, IO word offsets, wait-counter width.
package femto_mem_responder_pkg;

    localparam int unsigned CNT_W      = 4;
    localparam int unsigned DATA_W     = 32;
    localparam int unsigned LANES      = 4;
    localparam int unsigned IO_LEDS    = 0;
    localparam int unsigned IO_SCRATCH = 1;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        RD_WAIT = 2'd1,
        WR_WAIT = 2'd2
    } respState_t;

    // Load value for the wait counter; a zero wait never loads the counter.
    function automatic logic [CNT_W-1:0] waitLoad(input int unsigned waitCycles);
        return (waitCycles == 0) ? '0 : CNT_W'(waitCycles - 1);
    endfunction

endpackage

// File: rtl/femto_mem_responder_bram.sv
// Single-port RAM with four byte-write lanes and a registered, read-before-write output.
module femto_mem_responder_bram
    import femto_mem_responder_pkg::*;
#(
    parameter int unsigned ADDR_W = 12
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              readEn,
    input  logic [LANES-1:0]  writeEn,
    input  logic [ADDR_W-1:0] addr,
    input  logic [DATA_W-1:0] wdata,
    output logic [DATA_W-1:0] rdata
);

    logic [DATA_W-1:0] mem [0:(2**ADDR_W)-1];

    // Contents are never reset; only the output register is.
    always_ff @(posedge clk) begin
        for (int k = 0; k < int'(LANES); k++) begin
            if (writeEn[k]) begin
                mem[addr][8*k +: 8] <= wdata[8*k +: 8];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            rdata <= '0;
        end else if (readEn) begin
            rdata <= mem[addr];
        end
    end

endmodule

// File: rtl/femto_mem_responder.sv
// FemtoRV32 memory-bus responder: RAM-backed reads/byte-masked writes with programmable wait states.
// Optional IO page (LEDS/SCRATCH registers) enabled by defining RESP_IO_EN.
module femto_mem_responder
    import femto_mem_responder_pkg::*;
#(
    parameter int unsigned RAM_ADDR_W = 12,
    parameter int unsigned READ_WAIT  = 0,
    parameter int unsigned WRITE_WAIT = 0,
    parameter int unsigned IO_BIT     = 22
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [31:0]       mem_addr,
    input  logic [DATA_W-1:0] mem_wdata,
    input  logic [LANES-1:0]  mem_wmask,
    input  logic              mem_rstrb,
    output logic [DATA_W-1:0] mem_rdata,
    output logic              mem_rbusy,
    output logic              mem_wbusy,
    output logic [7:0]        leds
);

    localparam int unsigned BOTH_WAIT = (READ_WAIT >= WRITE_WAIT) ? READ_WAIT : WRITE_WAIT;

    respState_t              state;
    logic [CNT_W-1:0]        cnt;
    logic [RAM_ADDR_W-1:0]   wordIdx;
    logic                    wrAny;
    logic                    rdReq;
    logic                    wrReq;
    logic                    ioSel;
    logic [DATA_W-1:0]       ramRdata;
    logic                    unusedAddrBits;

    assign wordIdx = mem_addr[RAM_ADDR_W+1:2];
    assign wrAny   = |mem_wmask;
    assign rdReq   = reset && (state == IDLE) && mem_rstrb;
    assign wrReq   = reset && (state == IDLE) && wrAny;
    assign unusedAddrBits = ^{mem_addr[31:RAM_ADDR_W+2], mem_addr[1:0], mem_addr[IO_BIT]};

`ifdef RESP_IO_EN
    logic [7:0]        ledsReg;
    logic [DATA_W-1:0] scratch;
    logic [DATA_W-1:0] ioRdata;
    logic              ioSelQ;

    assign ioSel = mem_addr[IO_BIT];

    // IO page registers; reads are captured at accept just like RAM reads.
    always_ff @(posedge clk) begin
        if (!reset) begin
            ledsReg <= '0;
            scratch <= '0;
            ioRdata <= '0;
            ioSelQ  <= 1'b0;
        end else begin
            if (rdReq) begin
                ioSelQ <= ioSel;
                if (ioSel) begin
                    if (wordIdx == RAM_ADDR_W'(IO_LEDS)) begin
                        ioRdata <= {24'd0, ledsReg};
                    end else if (wordIdx == RAM_ADDR_W'(IO_SCRATCH)) begin
                        ioRdata <= scratch;
                    end else begin
                        ioRdata <= '0;
                    end
                end
            end
            if (wrReq && ioSel) begin
                if (wordIdx == RAM_ADDR_W'(IO_LEDS)) begin
                    if (mem_wmask[0]) begin
                        ledsReg <= mem_wdata[7:0];
                    end
                end else if (wordIdx == RAM_ADDR_W'(IO_SCRATCH)) begin
                    for (int k = 0; k < int'(LANES); k++) begin
                        if (mem_wmask[k]) begin
                            scratch[8*k +: 8] <= mem_wdata[8*k +: 8];
                        end
                    end
                end
            end
        end
    end

    assign mem_rdata = ioSelQ ? ioRdata : ramRdata;
    assign leds      = ledsReg;
`else
    assign ioSel     = 1'b0;
    assign mem_rdata = ramRdata;
    assign leds      = '0;
`endif

    femto_mem_responder_bram #(
        .ADDR_W (RAM_ADDR_W)
    ) u_bram (
        .clk     (clk),
        .reset   (reset),
        .readEn  (rdReq && !ioSel),
        .writeEn ((wrReq && !ioSel) ? mem_wmask : '0),
        .addr    (wordIdx),
        .wdata   (mem_wdata),
        .rdata   (ramRdata)
    );

    // Wait-state FSM; requests are only accepted in IDLE.
    always_ff @(posedge clk) begin
        if (!reset) begin
            state     <= IDLE;
            cnt       <= '0;
            mem_rbusy <= 1'b0;
            mem_wbusy <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (mem_rstrb && wrAny) begin
                        if (BOTH_WAIT != 0) begin
                            mem_rbusy <= 1'b1;
                            mem_wbusy <= 1'b1;
                            cnt       <= waitLoad(BOTH_WAIT);
                            state     <= (READ_WAIT >= WRITE_WAIT) ? RD_WAIT : WR_WAIT;
                        end
                    end else if (mem_rstrb) begin
                        if (READ_WAIT != 0) begin
                            mem_rbusy <= 1'b1;
                            cnt       <= waitLoad(READ_WAIT);
                            state     <= RD_WAIT;
                        end
                    end else if (wrAny) begin
                        if (WRITE_WAIT != 0) begin
                            mem_wbusy <= 1'b1;
                            cnt       <= waitLoad(WRITE_WAIT);
                            state     <= WR_WAIT;
                        end
                    end
                end
                RD_WAIT, WR_WAIT: begin
                    if (cnt == '0) begin
                        mem_rbusy <= 1'b0;
                        mem_wbusy <= 1'b0;
                        state     <= IDLE;
                    end else begin
                        cnt <= cnt - CNT_W'(1);
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_femto_mem_responder.sv
// Scoreboard bench: dut0 has no wait states, dut1 has READ_WAIT=3 / WRITE_WAIT=2.
module tb_femto_mem_responder;

    logic        clk;
    logic        reset;
    logic [31:0] addr  [2];
    logic [31:0] wdata [2];
    logic [3:0]  wmask [2];
    logic        rstrb [2];
    logic [31:0] rdata [2];
    logic        rbusy [2];
    logic        wbusy [2];
    logic [7:0]  leds  [2];

    int          checks;
    int          failures;
    logic [31:0] expQ0[$];
    logic [31:0] expQ1[$];
    logic        pend [2];
    int          rbC  [2];
    int          wbC  [2];

    femto_mem_responder #(.RAM_ADDR_W(12), .READ_WAIT(0), .WRITE_WAIT(0), .IO_BIT(22)) dut0 (
        .clk(clk), .reset(reset), .mem_addr(addr[0]), .mem_wdata(wdata[0]), .mem_wmask(wmask[0]),
        .mem_rstrb(rstrb[0]), .mem_rdata(rdata[0]), .mem_rbusy(rbusy[0]), .mem_wbusy(wbusy[0]),
        .leds(leds[0]));

    femto_mem_responder #(.RAM_ADDR_W(12), .READ_WAIT(3), .WRITE_WAIT(2), .IO_BIT(22)) dut1 (
        .clk(clk), .reset(reset), .mem_addr(addr[1]), .mem_wdata(wdata[1]), .mem_wmask(wmask[1]),
        .mem_rstrb(rstrb[1]), .mem_rdata(rdata[1]), .mem_rbusy(rbusy[1]), .mem_wbusy(wbusy[1]),
        .leds(leds[1]));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=0x%08h required=0x%08h", name, act, exp);
        end
    endtask

    task automatic pushExp(input int i, input logic [31:0] v);
        if (i == 0) expQ0.push_back(v);
        else        expQ1.push_back(v);
    endtask

    function automatic int expSize(input int i);
        return (i == 0) ? expQ0.size() : expQ1.size();
    endfunction

    function automatic logic [31:0] popExp(input int i);
        return (i == 0) ? expQ0.pop_front() : expQ1.pop_front();
    endfunction

    // Monitor: a read accepted in idle is compared once rbusy is low.
    always @(negedge clk) begin
        for (int i = 0; i < 2; i++) begin
            if (rbusy[i]) rbC[i]++;
            if (wbusy[i]) wbC[i]++;
            if (!reset) begin
                pend[i] = 1'b0;
            end else begin
                if (pend[i] && !rbusy[i]) begin
                    pend[i] = 1'b0;
                    if (expSize(i) == 0) begin
                        checks++;
                        failures++;
                        $display("FAIL rd_unexpected dut%0d actual=0x%08h required=none", i, rdata[i]);
                    end else begin
                        check($sformatf("rd_data_dut%0d", i), rdata[i], popExp(i));
                    end
                end
                if (rstrb[i] && !rbusy[i] && !wbusy[i]) pend[i] = 1'b1;
            end
        end
    end

    task automatic waitIdle(input int i);
        int n;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while ((rbusy[i] || wbusy[i]) && n < 50);
        if (rbusy[i] || wbusy[i]) begin
            checks++;
            failures++;
            $display("FAIL wait_idle_timeout dut%0d actual=busy required=idle", i);
        end
    endtask

    task automatic clearIn(input int i);
        addr[i] = '0; wdata[i] = '0; wmask[i] = '0; rstrb[i] = 1'b0;
    endtask

    task automatic doWrite(input int i, input logic [31:0] a, input logic [31:0] d, input logic [3:0] m);
        @(posedge clk); #1;
        addr[i] = a; wdata[i] = d; wmask[i] = m;
        @(posedge clk); #1;
        clearIn(i);
        waitIdle(i);
    endtask

    task automatic doRead(input int i, input logic [31:0] a, input logic [31:0] exp);
        pushExp(i, exp);
        @(posedge clk); #1;
        addr[i] = a; rstrb[i] = 1'b1;
        @(posedge clk); #1;
        clearIn(i);
        waitIdle(i);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int r0;
        int w0;
        checks = 0; failures = 0;
        for (int i = 0; i < 2; i++) begin
            clearIn(i); pend[i] = 1'b0; rbC[i] = 0; wbC[i] = 0;
        end
        reset = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        for (int i = 0; i < 2; i++) begin
            check($sformatf("rst_rdata_dut%0d", i), rdata[i], 32'h0);
            check($sformatf("rst_rbusy_dut%0d", i), 32'(rbusy[i]), 32'h0);
            check($sformatf("rst_wbusy_dut%0d", i), 32'(wbusy[i]), 32'h0);
            check($sformatf("rst_leds_dut%0d", i), 32'(leds[i]), 32'h0);
        end
        reset = 1'b1;

        // Zero wait states and byte lanes
        doWrite(0, 32'h10, 32'hDEADBEEF, 4'hF);
        doRead (0, 32'h10, 32'hDEADBEEF);
        doWrite(0, 32'h20, 32'h11223344, 4'hF);
        doWrite(0, 32'h20, 32'hAAAAAAAA, 4'b0100);
        doRead (0, 32'h20, 32'h11AA3344);
        doWrite(0, 32'h20, 32'h55660000, 4'b1100);
        doRead (0, 32'h20, 32'h55663344);

        // Write busy length, then read with a strobe issued mid-wait
        w0 = wbC[1];
        doWrite(1, 32'h40, 32'hCAFE0001, 4'hF);
        check("wbusy_len_write", 32'(wbC[1] - w0), 32'd2);
        doWrite(1, 32'h44, 32'h44444444, 4'hF);
        r0 = rbC[1];
        pushExp(1, 32'hCAFE0001);
        @(posedge clk); #1;
        addr[1] = 32'h40; rstrb[1] = 1'b1;
        @(posedge clk); #1;
        addr[1] = 32'h44; rstrb[1] = 1'b1; wmask[1] = 4'hF; wdata[1] = 32'hDEADDEAD;
        @(negedge clk);
        check("rbusy_first_cycle", 32'(rbusy[1]), 32'h1);
        check("rdata_first_busy", rdata[1], 32'hCAFE0001);
        @(posedge clk); #1;
        clearIn(1);
        waitIdle(1);
        check("rbusy_len_read", 32'(rbC[1] - r0), 32'd3);
        doRead(1, 32'h44, 32'h44444444);

        // Same-edge read and write: read-before-write, both flags for max wait
        w0 = wbC[1];
        doWrite(1, 32'h0, 32'h00000009, 4'hF);
        check("wbusy_len_write0", 32'(wbC[1] - w0), 32'd2);
        doWrite(1, 32'h4, 32'h00000001, 4'hF);
        r0 = rbC[1]; w0 = wbC[1];
        pushExp(1, 32'h00000001);
        @(posedge clk); #1;
        addr[1] = 32'h4; rstrb[1] = 1'b1; wmask[1] = 4'hF; wdata[1] = 32'h00000002;
        @(posedge clk); #1;
        clearIn(1);
        waitIdle(1);
        check("both_rbusy_len", 32'(rbC[1] - r0), 32'd3);
        check("both_wbusy_len", 32'(wbC[1] - w0), 32'd3);
        doRead(1, 32'h4, 32'h00000002);

        // Reset during a read wait
        @(posedge clk); #1;
        addr[1] = 32'h40; rstrb[1] = 1'b1;
        @(posedge clk); #1;
        clearIn(1);
        reset = 1'b0;
        @(negedge clk);
        check("rbusy_before_reset", 32'(rbusy[1]), 32'h1);
        @(posedge clk); #1;
        reset = 1'b1;
        check("reset_rbusy", 32'(rbusy[1]), 32'h0);
        check("reset_wbusy", 32'(wbusy[1]), 32'h0);
        check("reset_rdata", rdata[1], 32'h0);
        doRead(1, 32'h40, 32'hCAFE0001);
        doRead(1, 32'h4,  32'h00000002);
        doRead(1, 32'h0,  32'h00000009);

        // IO page (or RAM alias when the IO page is compiled out)
        doWrite(0, 32'h0, 32'h12345678, 4'hF);
        doWrite(0, 32'h00400000, 32'h000000A5, 4'hF);
`ifdef RESP_IO_EN
        check("leds_io", 32'(leds[0]), 32'hA5);
        doRead(0, 32'h0, 32'h12345678);
`else
        check("leds_io", 32'(leds[0]), 32'h0);
        doRead(0, 32'h0, 32'h000000A5);
`endif
        doRead (0, 32'h00400000, 32'h000000A5);
        doWrite(0, 32'h00400004, 32'hCAFEF00D, 4'hF);
        doRead (0, 32'h00400004, 32'hCAFEF00D);

        repeat (3) @(negedge clk);
        check("pending_dut0", 32'(expSize(0)), 32'h0);
        check("pending_dut1", 32'(expSize(1)), 32'h0);
        check("dut0_rbusy_cycles", 32'(rbC[0]), 32'h0);
        check("dut0_wbusy_cycles", 32'(wbC[0]), 32'h0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
